// File: rtl/sys_reset_pkg.sv
// sys_reset_pkg: shared types and helpers for the
// system reset controller.
package sys_reset_pkg;

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'b00,
      ST_RELEASE = 2'b01,
      ST_RUN     = 2'b10
   } rst_state_e;

   function automatic int CAUSE_LOCKUP(input int num_req);
      return num_req;
   endfunction

   function automatic int CAUSE_HRESET(input int num_req);
      return num_req + 1;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter with synchronous clear,
// saturating or wrapping on overflow.
module sat_counter #(
   parameter int WIDTH    = 8,
   parameter bit SATURATE = 1'b1
) (
   input  logic             sim_clock,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);
   import sys_reset_pkg::*;

   localparam logic [WIDTH-1:0] MAX = '1;

   logic at_max;
   assign at_max = SATURATE && (count == MAX);

   // clear wins over increment; saturating mode holds at MAX
   always_ff @(posedge sim_clock) begin
      if (clr) begin
         count <= '0;
      end else if (inc && !at_max) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/sys_reset_ctrl.sv
// sys_reset_ctrl: merges reset requests and lockup
// timeout, stretches and releases the AHB reset.
module sys_reset_ctrl #(
   parameter int NUM_REQ      = 2,
   parameter int HOLD_CYCLES  = 16,
   parameter int SYNC_STAGES  = 2,
   parameter int LOCKUP_LIMIT = 32,
   parameter int CNT_W        = 8
) (
   input  logic                 HCLK,
   input  logic                 HRESET,
   input  logic [NUM_REQ-1:0]   req_i,
   input  logic                 LOCKUP,
   input  logic                 TXEV,
   output logic                 HRESETn_out,
   output logic [NUM_REQ+1:0]   reset_cause,
   output logic [CNT_W-1:0]     rst_count,
   output logic [CNT_W-1:0]     txev_count,
   output logic                 lockup_rst
);
   import sys_reset_pkg::*;

   localparam int CW       = NUM_REQ + 2;
   localparam int LOCK_BIT = CAUSE_LOCKUP(NUM_REQ);
   localparam int HRST_BIT = CAUSE_HRESET(NUM_REQ);
   localparam int HW       = $clog2(HOLD_CYCLES + 1);
   localparam int LK_W     = (LOCKUP_LIMIT > 0) ?
                             $clog2(LOCKUP_LIMIT + 1) : 1;

   localparam logic [CW-1:0]   CAUSE_HRST =
      CW'(1) << HRST_BIT;
   localparam logic [HW-1:0]   HOLD_MAX =
      HW'(HOLD_CYCLES - 1);
   localparam logic [LK_W-1:0] LK_MAX =
      LK_W'((LOCKUP_LIMIT > 0) ? LOCKUP_LIMIT - 1 : 0);
   localparam bit LK_EN = (LOCKUP_LIMIT != 0);

   rst_state_e             state, state_nxt;
   logic [HW-1:0]          hold_cnt, hold_nxt;
   logic [LK_W-1:0]        lock_cnt, lock_nxt;
   logic [SYNC_STAGES-1:0] chain, chain_nxt;
   logic [SYNC_STAGES-1:0] chain_shift;
   logic [CW-1:0]          cause_nxt;
   logic                   lkrst_nxt;
   logic                   rst_inc;
   logic                   txev_inc;
   logic                   req_any;
   logic                   lock_hit;

   assign req_any  = |req_i;
   assign lock_hit = LK_EN && LOCKUP &&
                     (lock_cnt == LK_MAX);

   if (SYNC_STAGES > 1) begin : g_shift
      assign chain_shift =
         {chain[SYNC_STAGES-2:0], 1'b1};
   end else begin : g_shift1
      assign chain_shift = 1'b1;
   end

   assign HRESETn_out = chain[SYNC_STAGES-1];

   // state, counters and registered outputs
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state       <= ST_ASSERT;
         hold_cnt    <= '0;
         lock_cnt    <= '0;
         chain       <= '0;
         reset_cause <= CAUSE_HRST;
         lockup_rst  <= 1'b0;
      end else begin
         state       <= state_nxt;
         hold_cnt    <= hold_nxt;
         lock_cnt    <= lock_nxt;
         chain       <= chain_nxt;
         reset_cause <= cause_nxt;
         lockup_rst  <= lkrst_nxt;
      end
   end

   // next-state, counter updates and trigger decode
   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      lock_nxt  = '0;
      chain_nxt = chain;
      cause_nxt = reset_cause;
      lkrst_nxt = 1'b0;
      rst_inc   = 1'b0;
      txev_inc  = 1'b0;
      unique case (state)
         ST_ASSERT: begin
            chain_nxt = '0;
            if (req_any) begin
               hold_nxt = '0;
            end else if (hold_cnt == HOLD_MAX) begin
               hold_nxt  = '0;
               state_nxt = ST_RELEASE;
            end else begin
               hold_nxt = hold_cnt + 1'b1;
            end
         end
         ST_RELEASE: begin
            hold_nxt = '0;
            if (req_any) begin
               state_nxt = ST_ASSERT;
               chain_nxt = '0;
               cause_nxt = '0;
               cause_nxt[NUM_REQ-1:0] = req_i;
               rst_inc   = 1'b1;
            end else begin
               chain_nxt = chain_shift;
               if (chain_shift[SYNC_STAGES-1]) begin
                  state_nxt = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            hold_nxt = '0;
            txev_inc = TXEV;
            if (LK_EN && LOCKUP) begin
               lock_nxt = lock_cnt + 1'b1;
            end
            if (req_any || lock_hit) begin
               state_nxt = ST_ASSERT;
               chain_nxt = '0;
               lock_nxt  = '0;
               cause_nxt = '0;
               cause_nxt[NUM_REQ-1:0] = req_i;
               cause_nxt[LOCK_BIT]    = lock_hit;
               rst_inc   = 1'b1;
               lkrst_nxt = lock_hit;
            end
         end
         default: begin
            state_nxt = ST_ASSERT;
            hold_nxt  = '0;
            chain_nxt = '0;
         end
      endcase
   end

   sat_counter #(
      .WIDTH    (CNT_W),
      .SATURATE (1'b1)
   ) u_rst_cnt (
      .sim_clock (HCLK),
      .clr       (HRESET),
      .inc       (rst_inc),
      .count     (rst_count)
   );

   sat_counter #(
      .WIDTH    (CNT_W),
      .SATURATE (1'b0)
   ) u_txev_cnt (
      .sim_clock (HCLK),
      .clr       (HRESET),
      .inc       (txev_inc),
      .count     (txev_count)
   );

endmodule

// File: tb/tb_sys_reset_ctrl.sv
// tb_sys_reset_ctrl: directed and random stimulus
// against a cycle-count reference of the reset rules.
module tb_sys_reset_ctrl;

   localparam int NR   = 2;
   localparam int HOLD = 16;
   localparam int SYNC = 2;
   localparam int LIM  = 32;
   localparam int CW   = 8;
   localparam int LOWT = HOLD + SYNC;
   localparam int CMAX = (1 << CW) - 1;

   logic          sim_clock = 1'b0;
   logic          HRESET;
   logic [NR-1:0] req_i;
   logic          LOCKUP;
   logic          TXEV;
   logic          HRESETn_out;
   logic [NR+1:0] reset_cause;
   logic [CW-1:0] rst_count;
   logic [CW-1:0] txev_count;
   logic          lockup_rst;

   always #5 sim_clock = ~sim_clock;

   sys_reset_ctrl #(
      .NUM_REQ      (NR),
      .HOLD_CYCLES  (HOLD),
      .SYNC_STAGES  (SYNC),
      .LOCKUP_LIMIT (LIM),
      .CNT_W        (CW)
   ) dut (
      .HCLK        (sim_clock),
      .HRESET      (HRESET),
      .req_i       (req_i),
      .LOCKUP      (LOCKUP),
      .TXEV        (TXEV),
      .HRESETn_out (HRESETn_out),
      .reset_cause (reset_cause),
      .rst_count   (rst_count),
      .txev_count  (txev_count),
      .lockup_rst  (lockup_rst)
   );

   int n_vec = 0;
   int n_bad = 0;

   // reference: cycles since last reset event,
   // consecutive LOCKUP cycles while running
   int       m_since   = 0;
   int       m_lockrun = 0;
   int       m_rst     = 0;
   int       m_txev    = 0;
   logic [3:0] m_cause = 4'b1000;
   logic     m_lkp     = 1'b0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   task automatic model_edge(input logic [1:0] rq,
                             input logic lk,
                             input logic tx,
                             input logic hr);
      logic hit;
      m_lkp = 1'b0;
      if (hr) begin
         m_since   = 0;
         m_lockrun = 0;
         m_rst     = 0;
         m_txev    = 0;
         m_cause   = 4'b1000;
      end else if (m_since < LOWT) begin
         m_lockrun = 0;
         if (rq != 0) begin
            if (m_since >= HOLD) begin
               m_cause = {2'b00, rq};
               if (m_rst < CMAX) m_rst++;
            end
            m_since = 0;
         end else begin
            m_since++;
         end
      end else begin
         if (tx) m_txev = (m_txev + 1) % (CMAX + 1);
         hit = lk && (m_lockrun + 1 == LIM);
         m_lockrun = lk ? m_lockrun + 1 : 0;
         if (rq != 0 || hit) begin
            m_since   = 0;
            m_lockrun = 0;
            m_cause   = {1'b0, hit, rq};
            m_lkp     = hit;
            if (m_rst < CMAX) m_rst++;
         end
      end
   endtask

   task automatic step(input logic [1:0] rq,
                       input logic lk,
                       input logic tx,
                       input logic hr);
      req_i  = rq;
      LOCKUP = lk;
      TXEV   = tx;
      HRESET = hr;
      @(posedge sim_clock);
      model_edge(rq, lk, tx, hr);
      @(negedge sim_clock);
      chk("nrst", 32'(HRESETn_out),
          32'(m_since >= LOWT));
      chk("cause", 32'(reset_cause), 32'(m_cause));
      chk("rst_cnt", 32'(rst_count), 32'(m_rst));
      chk("txev_cnt", 32'(txev_count), 32'(m_txev));
      chk("lk_rst", 32'(lockup_rst), 32'(m_lkp));
   endtask

   task automatic idle();
      step(2'b00, 1'b0, 1'b0, 1'b0);
   endtask

   // event step, then count low cycles until release
   task automatic measure_low(input logic [1:0] rq,
                              input logic hr,
                              output int lows);
      step(rq, 1'b0, 1'b0, hr);
      lows = 0;
      for (int i = 0; i < 40; i++) begin
         if (HRESETn_out !== 1'b0) break;
         lows++;
         idle();
      end
   endtask

   task automatic wait_run();
      for (int i = 0; i < 40; i++) begin
         if (HRESETn_out === 1'b1) break;
         idle();
      end
      chk("run_reached", 32'(HRESETn_out), 32'd1);
   endtask

   int   lows;
   logic lk_on;
   logic [1:0] rq_r;

   initial begin
      HRESET = 1'b1;
      req_i  = '0;
      LOCKUP = 1'b0;
      TXEV   = 1'b0;

      // power-on: HRESET for three cycles
      step(2'b00, 1'b0, 1'b0, 1'b1);
      step(2'b00, 1'b0, 1'b0, 1'b1);
      measure_low(2'b00, 1'b1, lows);
      chk("por_low", 32'(lows), 32'(LOWT));
      chk("por_cause", 32'(reset_cause), 32'h8);
      chk("por_rst", 32'(rst_count), 32'd0);
      chk("por_txev", 32'(txev_count), 32'd0);

      // single request in RUN
      measure_low(2'b01, 1'b0, lows);
      chk("req_low", 32'(lows), 32'(LOWT));
      chk("req_cause", 32'(reset_cause), 32'h1);
      chk("req_rst", 32'(rst_count), 32'd1);

      // lockup held to the limit
      repeat (LIM - 1) step(2'b00, 1'b1, 1'b0, 1'b0);
      chk("lk_pre", 32'(HRESETn_out), 32'd1);
      step(2'b00, 1'b1, 1'b0, 1'b0);
      chk("lk_fire", 32'(HRESETn_out), 32'd0);
      chk("lk_pulse", 32'(lockup_rst), 32'd1);
      chk("lk_cause", 32'(reset_cause), 32'h4);
      idle();
      chk("lk_pulse_end", 32'(lockup_rst), 32'd0);
      wait_run();

      // lockup dropped one cycle short
      repeat (LIM - 1) step(2'b00, 1'b1, 1'b0, 1'b0);
      idle();
      chk("lk_drop", 32'(HRESETn_out), 32'd1);

      // request and lockup limit together
      repeat (LIM - 1) step(2'b00, 1'b1, 1'b0, 1'b0);
      step(2'b10, 1'b1, 1'b0, 1'b0);
      chk("both_cause", 32'(reset_cause), 32'h6);
      chk("both_rst", 32'(rst_count), 32'd3);

      // request during RELEASE restarts the low time
      repeat (HOLD + 1) idle();
      measure_low(2'b01, 1'b0, lows);
      chk("rel_low", 32'(lows), 32'(LOWT));
      chk("rel_rst", 32'(rst_count), 32'd4);
      chk("rel_cause", 32'(reset_cause), 32'h1);

      // TXEV wrap
      repeat (300) step(2'b00, 1'b0, 1'b1, 1'b0);
      chk("txev_wrap", 32'(txev_count), 32'd44);

      // rst_count saturation
      repeat (260) begin
         step(2'b01, 1'b0, 1'b0, 1'b0);
         repeat (LOWT) idle();
      end
      chk("rst_sat", 32'(rst_count), 32'(CMAX));

      // held request stays in ASSERT, counts once
      step(2'b10, 1'b0, 1'b0, 1'b0);
      repeat (40) step(2'b10, 1'b0, 1'b0, 1'b0);
      chk("held_low", 32'(HRESETn_out), 32'd0);

      // HRESET mid-ASSERT
      measure_low(2'b00, 1'b1, lows);
      chk("mid_low", 32'(lows), 32'(LOWT));
      chk("mid_cause", 32'(reset_cause), 32'h8);
      chk("mid_rst", 32'(rst_count), 32'd0);
      chk("mid_txev", 32'(txev_count), 32'd0);

      // randomized traffic
      lk_on = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) lk_on = ~lk_on;
         rq_r = 2'b00;
         if ($urandom_range(0, 59) == 0)
            rq_r = 2'($urandom_range(1, 3));
         step(rq_r, lk_on,
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 499) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/sys_reset_ctrl.md
# sys_reset_ctrl

Synthesizable, parametrised system reset and CPU-event controller for the Cortex-M0 subsystem. It sits between the board clock/reset and `system_top`, and drives the system's active-low AHB reset. It merges any number of reset-request sources plus an automatic LOCKUP-timeout reset, stretches and synchronously releases the reset, and records the cause of the last reset, the number of resets and the number of TXEV events.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of synchronous reset-request inputs (for example SYSRESETREQ and a watchdog).
- `HOLD_CYCLES`, default 16: minimum number of cycles the asserted reset is held, counted with all requests inactive. Must be ≥1.
- `SYNC_STAGES`, default 2: depth of the release shift chain. Must be ≥1.
- `LOCKUP_LIMIT`, default 32: number of consecutive LOCKUP cycles that triggers a reset. 0 disables the feature.
- `CNT_W`, default 8: width of `rst_count` and `txev_count`.

Ports:
- `HCLK`, in, 1: system clock. One clock domain only.
- `HRESET`, in, 1: reset. Synchronous, active-high.
- `req_i`, in, `NUM_REQ`: reset requests, level-sensitive, synchronous to `HCLK`.
- `LOCKUP`, in, 1: CPU lockup indication.
- `TXEV`, in, 1: CPU SEV event pulse.
- `HRESETn_out`, out, 1: active-low system reset to the AHB subsystem.
- `reset_cause`, out, `NUM_REQ+2`: cause of the last reset. Bits [`NUM_REQ-1`:0] = `req_i`, bit `NUM_REQ` = lockup, bit `NUM_REQ+1` = HRESET.
- `rst_count`, out, `CNT_W`: number of non-HRESET resets. Saturates at the maximum value.
- `txev_count`, out, `CNT_W`: number of TXEV cycles seen in RUN. Wraps.
- `lockup_rst`, out, 1: one-cycle pulse when a LOCKUP-timeout reset is triggered.

## Operation
State machine with three states: ASSERT, RELEASE, RUN.

HRESET=1, at the clock edge:
- state → ASSERT; `HRESETn_out`=0.
- Hold counter, sync chain, lockup counter, `rst_count` and `txev_count` all → 0.
- `reset_cause` → one-hot HRESET bit; `lockup_rst`=0.
- HRESET overrides every other input in every state.

ASSERT:
- `HRESETn_out`=0.
- Hold counter increments while `req_i`==0. Any active request clears it to 0.
- When the counter reaches `HOLD_CYCLES`-1 with no request → RELEASE.

RELEASE:
- Each cycle a 1 shifts into the sync chain. `HRESETn_out` = last stage of the chain.
- After `SYNC_STAGES` cycles → RUN.
- Any request → ASSERT, with the chain cleared to 0.

RUN:
- `HRESETn_out`=1.
- Lockup counter increments while LOCKUP=1 and clears when LOCKUP=0.
- Trigger condition: (`req_i`!=0) or (`LOCKUP_LIMIT`≠0 and lockup counter == `LOCKUP_LIMIT`-1 with LOCKUP=1).
- On a trigger:
  - state → ASSERT.
  - `reset_cause` is overwritten with the sources active that cycle.
  - `rst_count` increments (saturating).
  - `lockup_rst` pulses if lockup contributed.
- A request seen in RELEASE also updates `reset_cause` and `rst_count`.

TXEV:
- `txev_count` increments by 1 in every RUN cycle with TXEV=1, including the cycle a reset triggers.
- Ignored in ASSERT and RELEASE.

Arithmetic:
- Counters are unsigned.
- `rst_count` holds at 2^`CNT_W`-1.
- `txev_count` wraps to 0.
- Hold and lockup counters are sized `$clog2(max+1)`.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Request sampled at edge k in RUN → `HRESETn_out`=0 after edge k. Latency is 1 cycle.
- Minimum low time after the last request/HRESET cycle is `HOLD_CYCLES`+`SYNC_STAGES` cycles. With defaults that is 18.
- LOCKUP held continuously from edge j → reset after edge j+`LOCKUP_LIMIT`-1.
- `reset_cause`, `rst_count` and `lockup_rst` update at the same edge on which `HRESETn_out` falls.

Boundary cases:
- `req_i` and lockup limit in the same cycle: both cause bits set; `rst_count` increments once.
- Request held indefinitely: the controller stays in ASSERT. `rst_count` does not increment again.
- HRESET asserted mid-RELEASE or mid-ASSERT: takes effect next edge. Cause becomes HRESET only; counters clear.
- LOCKUP dropping one cycle before the limit: lockup counter → 0, no reset.

## Structure
- Package `sys_reset_pkg` holds:
  - state encoding (ASSERT=2'b00, RELEASE=2'b01, RUN=2'b10);
  - cause-bit index functions (`CAUSE_LOCKUP(NUM_REQ)`, `CAUSE_HRESET(NUM_REQ)`).
- One sub-module, `sat_counter` (parameters width, saturate/wrap mode; inputs inc and clr). It is instantiated for `rst_count` (saturate) and `txev_count` (wrap). The hold and lockup counters stay inline.

## Test plan
All scenarios use default parameters.
- HRESET high for 3 cycles, then low → `HRESETn_out` low for exactly 18 cycles, then high; `reset_cause`=4'b1000; both counts 0.
- In RUN, `req_i`=2'b01 for 1 cycle → `HRESETn_out` low next edge for 18 cycles; `reset_cause`=4'b0001; `rst_count`=1.
- LOCKUP held 32 cycles → reset at cycle 32; `lockup_rst` one-cycle pulse; cause=4'b0100. LOCKUP held 31 cycles then dropped → no reset.
- `req_i`=2'b10 and lockup limit reached in the same cycle → cause=4'b0110; `rst_count` +1. Request re-asserted during RELEASE → back to ASSERT; low time restarts at 18.
- 300 TXEV pulses in RUN → `txev_count`=44 (wrapped). 260 forced reset events → `rst_count`=255.
- HRESET pulsed during ASSERT with counts non-zero → counts 0; cause=4'b1000; full 18-cycle sequence restarts.
